// File: rtl/ahb_bridge_pkg.sv
// Shared encodings, FSM state type and default address map for the AHB2APB bridge.
package ahb_bridge_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h8000_0000;
  localparam logic [31:0] DEF_REGION_SIZE = 32'h0400_0000;

  // Only NONSEQ and SEQ carry a real transfer.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational decode of HADDR into NUM_SEL equal power-of-two regions above BASE_ADDR.
module ahb_addr_decode
  import ahb_bridge_pkg::*;
#(
  parameter int unsigned          ADDR_W      = 32,
  parameter int unsigned          NUM_SEL     = 3,
  parameter logic [ADDR_W-1:0]    BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [ADDR_W-1:0]    REGION_SIZE = ADDR_W'(DEF_REGION_SIZE)
) (
  input  logic [ADDR_W-1:0]  HADDR,
  output logic               mapped,
  output logic [NUM_SEL-1:0] sel
);

  localparam int unsigned    SHIFT = $clog2(REGION_SIZE);
  // One extra bit so the span end cannot wrap for large maps.
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(NUM_SEL) * (ADDR_W+1)'(REGION_SIZE);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] region;

  assign offset = HADDR - BASE_ADDR;
  assign region = offset >> SHIFT;
  assign mapped = (HADDR >= BASE_ADDR) && ({1'b0, offset} < SPAN);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      sel[i] = mapped && (region == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/ahb_slave_if_ws.sv
// AHB-Lite slave front end: decodes, holds the transfer and stalls until the APB side is done.
// Define AHB_SLV_ERR_RESP_EN to answer unmapped addresses with the two-cycle ERROR response.
module ahb_slave_if_ws
  import ahb_bridge_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_SEL     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [ADDR_W-1:0] REGION_SIZE = ADDR_W'(DEF_REGION_SIZE)
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [ADDR_W-1:0]  HADDR,
  input  logic [DATA_W-1:0]  HWDATA,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic               HREADYin,
  output logic               HREADYout,
  output logic [1:0]         HRESP,
  output logic [DATA_W-1:0]  HRDATA,
  input  logic [DATA_W-1:0]  PRDATA,
  input  logic               apb_done,
  output logic               valid,
  output logic [ADDR_W-1:0]  HADDR_q,
  output logic [DATA_W-1:0]  HWDATA_q,
  output logic               HWRITEreg,
  output logic [2:0]         HSIZEreg,
  output logic [NUM_SEL-1:0] TEMP_SEL
);

  state_e             state;
  logic               mapped;
  logic [NUM_SEL-1:0] sel;
  logic               accept;

  ahb_addr_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_SEL     (NUM_SEL),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_SIZE (REGION_SIZE)
  ) u_decode (
    .HADDR  (HADDR),
    .mapped (mapped),
    .sel    (sel)
  );

  assign accept = HREADYin && is_active(HTRANS);

  // Ready follows the APB side during a transfer; only the first ERROR cycle stalls otherwise.
  assign HREADYout = (state == ST_XFER) ? apb_done : (state != ST_ERR1);
  assign HRDATA    = PRDATA;

`ifdef AHB_SLV_ERR_RESP_EN
  hresp_e hresp_q;
  assign HRESP = hresp_q;
`else
  assign HRESP = HRESP_OKAY;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      valid     <= 1'b0;
      HADDR_q   <= '0;
      HWDATA_q  <= '0;
      HWRITEreg <= 1'b0;
      HSIZEreg  <= '0;
      TEMP_SEL  <= '0;
`ifdef AHB_SLV_ERR_RESP_EN
      hresp_q   <= HRESP_OKAY;
`endif
    end else begin
      // Master keeps write data stable across wait states.
      if (state == ST_XFER) HWDATA_q <= HWDATA;

`ifdef AHB_SLV_ERR_RESP_EN
      if (state == ST_ERR1) begin
        state   <= ST_ERR2;
        hresp_q <= HRESP_ERROR;
      end else
`endif
      if (HREADYout) begin
`ifdef AHB_SLV_ERR_RESP_EN
        hresp_q <= HRESP_OKAY;
`endif
        if (accept && mapped) begin
          state     <= ST_XFER;
          valid     <= 1'b1;
          HADDR_q   <= HADDR;
          HWRITEreg <= HWRITE;
          HSIZEreg  <= HSIZE;
          TEMP_SEL  <= sel;
        end
`ifdef AHB_SLV_ERR_RESP_EN
        else if (accept) begin
          state   <= ST_ERR1;
          valid   <= 1'b0;
          hresp_q <= HRESP_ERROR;
        end
`endif
        else begin
          state <= ST_IDLE;
          valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/ahb_slave_if_ws.md
# ahb_slave_if_ws

Parametrised AHB-Lite slave front end for the AHB2APB bridge. Decodes the transfer address into one of `NUM_SEL` equal-sized APB regions and registers the address, write data and direction. Stalls the AHB master with wait states until the APB side reports completion. Optionally returns the two-cycle AHB ERROR response for unmapped addresses.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `NUM_SEL`, 3, number of APB regions / select bits (1..8)
- `BASE_ADDR`, 32'h8000_0000, start of region 0
- `REGION_SIZE`, 32'h0400_0000, bytes per region; power of two
- `HCLK` in 1 — bus clock; all logic on rising edge
- `HRESET` in 1 — synchronous, active-high reset
- `HADDR` in ADDR_W — address-phase address
- `HWDATA` in DATA_W — data-phase write data
- `HTRANS` in 2 — IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- `HWRITE` in 1 — address-phase direction
- `HSIZE` in 3 — passed through to `HSIZEreg`
- `HREADYin` in 1 — bus HREADY
- `HREADYout` out 1 — slave ready
- `HRESP` out 2 — OKAY=00, ERROR=01
- `HRDATA` out DATA_W — equals `PRDATA`, combinational
- `PRDATA` in DATA_W — read data from APB side
- `apb_done` in 1 — APB side finished current transfer
- `valid` out 1 — transfer pending for APB side
- `HADDR_q` out ADDR_W, `HWDATA_q` out DATA_W, `HWRITEreg` out 1, `HSIZEreg` out 3 — held transfer
- `TEMP_SEL` out NUM_SEL — one-hot region select, registered

## Operation
- Accept = `HREADYin` & HTRANS∈{NONSEQ,SEQ}, evaluated only when `HREADYout`=1. IDLE/BUSY are never accepted and get OKAY.
- Mapped = `BASE_ADDR` ≤ HADDR < `BASE_ADDR`+`NUM_SEL`·`REGION_SIZE` (half-open). Index = (HADDR−BASE_ADDR)>>log2(REGION_SIZE).
- FSM states: IDLE, XFER, ERR1, ERR2.
- IDLE: `HREADYout`=1, OKAY. A mapped accept latches HADDR_q, HWRITEreg, HSIZEreg and one-hot TEMP_SEL, then goes to XFER. An unmapped accept goes to ERR1.
- XFER: `valid`=1. `HWDATA_q`←HWDATA every cycle (master holds it stable). `HREADYout`=`apb_done`.
  - `apb_done`=1: evaluate accept. Mapped → XFER with new latch; unmapped → ERR1; none → IDLE.
- ERR1: `HREADYout`=0, ERROR, `valid`=0. ERR2: `HREADYout`=1, ERROR; accept evaluated as in IDLE.
- `apb_done` outside XFER is ignored. TEMP_SEL and HADDR_q hold their last value in IDLE.

## Timing
- Reset values: HADDR_q=0, HWDATA_q=0, HWRITEreg=0, HSIZEreg=0, TEMP_SEL=0, valid=0, HRESP=00, HREADYout=1, state IDLE.
- HRESET in any state → IDLE on the next edge; a pending transfer is dropped; no ERROR is issued.
- Latency: valid rises 1 cycle after accept. Minimum data phase is 1 cycle (apb_done in first XFER cycle). Each cycle without apb_done adds one wait state.
- Back-to-back: next address is accepted in the apb_done cycle, with no IDLE gap.
- ERROR response is exactly 2 cycles (ERR1, ERR2).

## Configuration
- `AHB_SLV_ERR_RESP_EN` defined: unmapped accepts take ERR1→ERR2.
- Not defined: ERR states are not built. Unmapped accepts stay in IDLE, get OKAY, and cause no stall or register update; HRESP is tied to 00.

## Structure
- Package `ahb_bridge_pkg` holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
  - HRESP codes (OKAY/ERROR)
  - FSM state enum
  - default BASE_ADDR / REGION_SIZE constants
- Sub-module `ahb_addr_decode`: combinational; takes HADDR and produces `mapped` plus the one-hot select, parametrised by BASE_ADDR, REGION_SIZE and NUM_SEL.

## Test plan
Defaults throughout.
- **Reset:** HRESET high 2 cycles with random inputs → all outputs at reset values, HREADYout=1.
- **Write with wait states:** NONSEQ write to 0x8400_0010, HWDATA=0xDEAD_BEEF, apb_done in 3rd XFER cycle → TEMP_SEL=3'b010, valid high 3 cycles, HREADYout low 2 cycles, HWDATA_q=0xDEAD_BEEF, HWRITEreg=1.
- **Zero-wait read plus back-to-back:** NONSEQ read 0x8000_0004, PRDATA=0x1234_5678, apb_done in first XFER cycle, SEQ read to 0x8800_0000 presented the same cycle → HRDATA=0x1234_5678, TEMP_SEL 001 then 100, valid continuous.
- **Unmapped address:** NONSEQ to 0x8C00_0000 → with macro: HRESP=01 for 2 cycles, HREADYout 0 then 1, valid=0. Without macro: HRESP=00, HREADYout stays 1.
- **BUSY ignored:** HTRANS=BUSY to 0x8000_0000 → no state change, valid=0, OKAY.
- **Reset mid-transfer:** HRESET asserted in 2nd XFER cycle → next edge valid=0, HREADYout=1, TEMP_SEL=0.
